// File: rtl/sys_ctrl.sv
// sys_ctrl: system control for the MIDI synth top level.
// Provides a stretched synchronous reset (restartable by MIDI reset command),
// push-button debouncing with press pulses, and mode-selectable LED status.
// Optional macro SYS_CTRL_BP_RST_EN: a long press on button 0 requests a reset.
module sys_ctrl #(
  parameter int unsigned NB_BP      = 4,
  parameter int unsigned NB_LED     = 4,
  parameter int unsigned RST_CYCLES = 15,
  parameter int unsigned DEBOUNCE_W = 16,
  parameter int unsigned ACT_W      = 20,
  parameter int unsigned LONG_W     = 26
) (
  input  logic              clk96,
  input  logic              rst_n,
  input  logic [NB_BP-1:0]  bp,
  input  logic              rst_cmd,
  input  logic              note_pressed,
  input  logic              pitch_wheel,
  input  logic [6:0]        note,
  output logic              rst_out,
  output logic [NB_BP-1:0]  bp_level,
  output logic [NB_BP-1:0]  bp_press,
  output logic [NB_LED-1:0] led,
  output logic [1:0]        led_mode
);

  localparam int unsigned RST_W = 16;
  localparam logic [RST_W-1:0]      RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [DEBOUNCE_W-1:0] DB_MAX   = '1;
  localparam logic [DEBOUNCE_W-1:0] DB_LAST  = DB_MAX - DEBOUNCE_W'(1);
  localparam logic [ACT_W-1:0]      ACT_MAX  = '1;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } rst_state_t;

  rst_state_t              state;
  logic [RST_W-1:0]        rst_cnt;
  logic                    rst_req;
  logic                    rst_nxt;

  logic [NB_BP-1:0]        sync1;
  logic [NB_BP-1:0]        sync2;
  logic [DEBOUNCE_W-1:0]   db_cnt [NB_BP];
  logic [NB_BP-1:0]        level_nxt;

  logic [ACT_W-1:0]        act_cnt;
  logic [ACT_W-1:0]        act_nxt;
  logic [NB_LED-1:0]       legacy;
  logic [NB_LED-1:0]       legacy_nxt;
  logic [1:0]              mode_nxt;
  logic [NB_LED-1:0]       led_nxt;

  // Only note[NB_LED+1:2] drives LEDs; fold the whole bus here to mark the rest as intentionally unused
  logic unused_note;
  assign unused_note = ^note;

`ifdef SYS_CTRL_BP_RST_EN
  localparam logic [LONG_W-1:0] LONG_MAX  = '1;
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_MAX - LONG_W'(1);

  logic [LONG_W-1:0] long_cnt;
  logic              long_req;

  // Fires once, on the cycle the hold counter reaches its saturation value
  assign long_req = bp_level[0] && (long_cnt == LONG_LAST);

  // Long-press hold counter on button 0, saturating so one request per hold
  always_ff @(posedge clk96 or negedge rst_n) begin
    if (!rst_n) begin
      long_cnt <= '0;
    end else if (!bp_level[0]) begin
      long_cnt <= '0;
    end else if (long_cnt != LONG_MAX) begin
      long_cnt <= long_cnt + LONG_W'(1);
    end
  end

  assign rst_req = rst_cmd | long_req;
`else
  logic [LONG_W-1:0] unused_long;
  assign unused_long = '0;
  assign rst_req     = rst_cmd;
`endif

  // Next rst_out value; shared so reset-cleared registers line up with rst_out
  assign rst_nxt = rst_req || ((state == HOLD) && (rst_cnt != RST_LAST));

  // Reset stretch FSM: HOLD counts RST_CYCLES cycles, any reset cause restarts it
  always_ff @(posedge clk96 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= HOLD;
      rst_cnt <= '0;
      rst_out <= 1'b1;
    end else begin
      rst_out <= rst_nxt;
      case (state)
        HOLD: begin
          if (rst_req) begin
            rst_cnt <= '0;
          end else if (rst_cnt == RST_LAST) begin
            state <= RUN;
          end else begin
            rst_cnt <= rst_cnt + RST_W'(1);
          end
        end
        RUN: begin
          if (rst_req) begin
            state   <= HOLD;
            rst_cnt <= '0;
          end
        end
        default: begin
          state   <= HOLD;
          rst_cnt <= '0;
        end
      endcase
    end
  end

  // Debounced level flips once the synchronised input has disagreed for 2^DEBOUNCE_W-1 cycles
  always_comb begin
    level_nxt = bp_level;
    for (int i = 0; i < int'(NB_BP); i++) begin
      if ((sync2[i] != bp_level[i]) && (db_cnt[i] == DB_LAST)) begin
        level_nxt[i] = ~bp_level[i];
      end
    end
  end

  // Synchronisers, debounce counters, levels and press pulses
  always_ff @(posedge clk96 or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      bp_level <= '0;
      bp_press <= '0;
      for (int i = 0; i < int'(NB_BP); i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1    <= bp;
      sync2    <= sync1;
      bp_level <= level_nxt;
      bp_press <= level_nxt & ~bp_level & {NB_BP{~rst_nxt}};
      for (int i = 0; i < int'(NB_BP); i++) begin
        if ((sync2[i] == bp_level[i]) || (db_cnt[i] == DB_LAST)) begin
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DEBOUNCE_W'(1);
        end
      end
    end
  end

  // Next display mode, activity stretch, legacy capture and LED image
  always_comb begin
    mode_nxt   = led_mode;
    act_nxt    = act_cnt;
    legacy_nxt = legacy;
    led_nxt    = '0;

    if (rst_nxt) begin
      mode_nxt = 2'd0;
    end else if (bp_press[NB_BP-1]) begin
      mode_nxt = (led_mode == 2'd2) ? 2'd0 : led_mode + 2'd1;
    end

    if (note_pressed) begin
      act_nxt = ACT_MAX;
    end else if (act_cnt != '0) begin
      act_nxt = act_cnt - ACT_W'(1);
    end

    if (rst_nxt) begin
      legacy_nxt = '0;
    end else if (pitch_wheel && (led_mode == 2'd0)) begin
      legacy_nxt = note[NB_LED+1:2];
    end

    case (mode_nxt)
      2'd0: led_nxt = legacy_nxt;
      2'd1: begin
        led_nxt[0] = (act_nxt != '0);
        for (int i = 1; i < int'(NB_LED); i++) begin
          led_nxt[i] = (i <= int'(NB_BP)) ? level_nxt[(i-1) % int'(NB_BP)] : 1'b0;
        end
      end
      2'd2: led_nxt[0] = rst_nxt;
      default: led_nxt = '0;
    endcase
  end

  // Registered LED outputs and their state
  always_ff @(posedge clk96 or negedge rst_n) begin
    if (!rst_n) begin
      led_mode <= 2'd0;
      act_cnt  <= '0;
      legacy   <= '0;
      led      <= '0;
    end else begin
      led_mode <= mode_nxt;
      act_cnt  <= act_nxt;
      legacy   <= legacy_nxt;
      led      <= led_nxt;
    end
  end

endmodule

// File: tb/tb_sys_ctrl.sv
// Testbench for sys_ctrl: directed scenarios plus random stimulus, checked
// every cycle against a behavioural reference model through a scoreboard queue.
module tb_sys_ctrl;

  localparam int NB_BP      = 4;
  localparam int NB_LED     = 4;
  localparam int RST_CYCLES = 15;
  localparam int DEB_W      = 3;
  localparam int ACT_W      = 4;
  localparam int LONG_W     = 5;
  localparam int DEB_STABLE = (1 << DEB_W) - 1;
  localparam int ACT_LOAD   = (1 << ACT_W) - 1;
  localparam int LONG_MAX   = (1 << LONG_W) - 1;

  logic              clk96 = 1'b0;
  logic              rst_n = 1'b1;
  logic [NB_BP-1:0]  bp = '0;
  logic              rst_cmd = 1'b0;
  logic              note_pressed = 1'b0;
  logic              pitch_wheel = 1'b0;
  logic [6:0]        note = '0;
  logic              rst_out;
  logic [NB_BP-1:0]  bp_level;
  logic [NB_BP-1:0]  bp_press;
  logic [NB_LED-1:0] led;
  logic [1:0]        led_mode;

  sys_ctrl #(
    .NB_BP(NB_BP), .NB_LED(NB_LED), .RST_CYCLES(RST_CYCLES),
    .DEBOUNCE_W(DEB_W), .ACT_W(ACT_W), .LONG_W(LONG_W)
  ) dut (
    .clk96(clk96), .rst_n(rst_n), .bp(bp), .rst_cmd(rst_cmd),
    .note_pressed(note_pressed), .pitch_wheel(pitch_wheel), .note(note),
    .rst_out(rst_out), .bp_level(bp_level), .bp_press(bp_press),
    .led(led), .led_mode(led_mode)
  );

  always #5 clk96 = ~clk96;

  typedef struct packed {
    logic       rst;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] led;
    logic [1:0] mode;
  } snap_t;

  snap_t exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc_no = 0;
  bit    armed = 0;

  // Reference model state
  int         m_age, m_act, m_hold;
  logic       m_rst;
  logic [3:0] m_level, m_press, m_legacy, m_led;
  logic [1:0] m_mode;
  logic [3:0] hist [0:8];

  // Directed-scenario observers
  bit count_win = 0;
  bit rst_win   = 0;
  int press1_cnt = 0;
  int rst_rise   = 0;
  logic rst_prev = 1'b1;

  // Reference model: computes the expected outputs after each clock edge
  always @(posedge clk96) begin : ref_model
    logic [3:0] pl, pp;
    logic [1:0] pmode;
    logic       cause;
    bit         all_diff;
    if (!rst_n) begin
      m_age = 0; m_rst = 1'b1; m_level = '0; m_press = '0; m_mode = '0;
      m_act = 0; m_hold = 0; m_legacy = '0;
      for (int k = 0; k <= 8; k++) hist[k] = '0;
    end else begin
      pl = m_level; pp = m_press; pmode = m_mode;
      cause = rst_cmd;
`ifdef SYS_CTRL_BP_RST_EN
      if (pl[0]) begin
        if (m_hold < LONG_MAX) begin
          m_hold = m_hold + 1;
          if (m_hold == LONG_MAX) cause = 1'b1;
        end
      end else begin
        m_hold = 0;
      end
`endif
      // Age since the last reset cause; reset is active for RST_CYCLES cycles
      if (cause) m_age = 0;
      else if (m_age < RST_CYCLES) m_age = m_age + 1;
      m_rst = (m_age < RST_CYCLES);
      // Raw history; the level flips when samples 2..8 edges old all disagree with it
      for (int k = 8; k >= 1; k--) hist[k] = hist[k-1];
      hist[0] = bp;
      for (int i = 0; i < NB_BP; i++) begin
        all_diff = 1;
        for (int k = 2; k < 2 + DEB_STABLE; k++)
          if (hist[k][i] == pl[i]) all_diff = 0;
        if (all_diff) m_level[i] = ~pl[i];
      end
      m_press = m_level & ~pl & {4{~m_rst}};
      if (m_rst) m_mode = 2'd0;
      else if (pp[3]) m_mode = (pmode == 2'd2) ? 2'd0 : pmode + 2'd1;
      if (note_pressed) m_act = ACT_LOAD;
      else if (m_act > 0) m_act = m_act - 1;
      if (m_rst) m_legacy = '0;
      else if (pitch_wheel && pmode == 2'd0) m_legacy = note[5:2];
    end
    case (m_mode)
      2'd0:    m_led = m_legacy;
      2'd1:    m_led = {m_level[2:0], (m_act != 0)};
      2'd2:    m_led = {3'b000, m_rst};
      default: m_led = '0;
    endcase
    exp_q.push_back({m_rst, m_level, m_press, m_led, m_mode});
    armed = 1;
    cyc_no++;
  end

  // Monitor: pops one expected snapshot per cycle and compares against the DUT
  always @(negedge clk96) begin : monitor
    snap_t e, a;
    if (armed) begin
      a = {rst_out, bp_level, bp_press, led, led_mode};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_empty cycle %0d: no expected entry", cyc_no);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          fails++;
          if (fails <= 40)
            $display("FAIL outputs cycle %0d: got rst=%b lvl=%b prs=%b led=%b mode=%0d, expected rst=%b lvl=%b prs=%b led=%b mode=%0d",
                     cyc_no, a.rst, a.level, a.press, a.led, a.mode,
                     e.rst, e.level, e.press, e.led, e.mode);
        end
      end
      if (count_win && bp_press[1]) press1_cnt++;
      if (rst_win && rst_out && !rst_prev) rst_rise++;
      rst_prev = rst_out;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk96);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, expv);
    end
  endtask

  task automatic press3();
    bp[3] = 1'b1; cyc(12);
    bp[3] = 1'b0; cyc(12);
  endtask

  // Stimulus
  initial begin
    int idx;
    #1 rst_n = 1'b0;
    #2;
    check("reset_state", 32'({rst_out, bp_level, bp_press, led, led_mode}), 32'({1'b1, 14'b0}));
    repeat (3) @(posedge clk96);
    #1 rst_n = 1'b1;

    // Power-up stretch, then two overlapping MIDI reset commands
    cyc(40);
    rst_cmd = 1'b1; cyc(1); rst_cmd = 1'b0;
    cyc(4);
    rst_cmd = 1'b1; cyc(1); rst_cmd = 1'b0;
    cyc(30);

    // Bouncing button 1 followed by a steady press: one clean pulse
    count_win = 1;
    for (int k = 0; k < 6; k++) begin
      bp[1] = (k % 2 == 0); cyc(1);
    end
    bp[1] = 1'b1; cyc(20);
    count_win = 0;
    check("bounce_press_count", 32'(press1_cnt), 32'd1);
    bp[1] = 1'b0; cyc(15);

    // Legacy mode capture
    note = 7'h2C; pitch_wheel = 1'b1; cyc(1);
    pitch_wheel = 1'b0; note = '0;
    check("mode0_led", 32'(led), 32'b1011);

    // Two presses of the mode button -> status mode
    press3(); press3();
    check("mode2_mode", 32'(led_mode), 32'd2);
    check("mode2_led", 32'(led), 32'd0);

    // Two more presses -> activity mode
    press3(); press3();
    check("mode1_mode", 32'(led_mode), 32'd1);
    note_pressed = 1'b1; cyc(1); note_pressed = 1'b0;
    check("mode1_act_led0", 32'(led[0]), 32'd1);
    cyc(20);
    check("mode1_act_expired", 32'(led[0]), 32'd0);
    bp[0] = 1'b1; cyc(15);
    check("mode1_bp0_led1", 32'(led[1]), 32'd1);
    bp[0] = 1'b0; cyc(15);

    // Long hold on button 0
    rst_win = 1;
    bp[0] = 1'b1; cyc(60);
    bp[0] = 1'b0; cyc(30);
    rst_win = 0;
`ifdef SYS_CTRL_BP_RST_EN
    check("long_press_resets", 32'(rst_rise), 32'd1);
`else
    check("long_press_resets", 32'(rst_rise), 32'd0);
`endif

    // Random traffic
    for (int n = 0; n < 2500; n++) begin
      rst_cmd      = ($urandom_range(0, 299) == 0);
      note_pressed = ($urandom_range(0, 7) == 0);
      pitch_wheel  = ($urandom_range(0, 5) == 0);
      note         = 7'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        idx = int'($urandom_range(0, NB_BP - 1));
        bp[idx] = ~bp[idx];
      end
      cyc(1);
    end
    rst_cmd = 1'b0; note_pressed = 1'b0; pitch_wheel = 1'b0;
    cyc(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sys_ctrl.md
Name: sys_ctrl

Overview:
- Parametrised system-control block for the MIDI synth top level.
- Generates the design-wide synchronous reset with a programmable stretch, restartable by the MIDI reset command.
- Debounces NB_BP push-buttons into clean levels and single-cycle press pulses.
- Drives NB_LED status LEDs in a button-selectable display mode. Replaces the fixed 4-bit reset counter and hard-wired LED latch.

Parameters:
- NB_BP, 4, number of push-buttons (2..8).
- NB_LED, 4, number of LEDs (1..5).
- RST_CYCLES, 15, clk96 cycles rst_out stays high after the last reset cause is removed (1..65535).
- DEBOUNCE_W, 16, debounce counter width; a level must be stable for 2^DEBOUNCE_W-1 cycles.
- ACT_W, 20, activity-stretch counter width for LED mode 1.
- LONG_W, 26, long-press counter width (used only with BP_RST_EN).

Ports:
- clk96  in  1  system clock, 96 MHz.
- rst_n  in  1  asynchronous active-low reset.
- bp  in  NB_BP  raw asynchronous button inputs, active-high.
- rst_cmd  in  1  one-cycle MIDI reset-command pulse (clk96 domain).
- note_pressed  in  1  one-cycle note-on pulse.
- pitch_wheel  in  1  one-cycle pitch-wheel event pulse.
- note  in  7  MIDI note/data value, valid with pitch_wheel.
- rst_out  out  1  active-high synchronous reset to the rest of the design.
- bp_level  out  NB_BP  debounced button levels.
- bp_press  out  NB_BP  one-cycle pulse on each debounced 0->1 edge.
- led  out  NB_LED  LED drive, active-high.
- led_mode  out  2  current display mode.

Behaviour:
- rst_n low, asynchronous: rst_out=1, bp_level=0, bp_press=0, led=0, led_mode=0, all counters 0, FSM=HOLD.
- Reset FSM states:
  - HOLD: rst_out=1, counter increments each cycle. When the counter reaches RST_CYCLES-1, go to RUN.
  - RUN: rst_out=0.
- rst_out is registered. The first cycle with rst_out=0 is exactly RST_CYCLES cycles after the rst_n rising edge is sampled.
- rst_cmd in RUN: next cycle FSM=HOLD, counter=0, rst_out=1, full RST_CYCLES stretch.
- rst_cmd in HOLD: counter cleared to 0, extending the stretch.
- Debounce, per button:
  - 2-FF synchroniser, then counter.
  - Synchronised input != bp_level: counter increments.
  - Counter reaches 2^DEBOUNCE_W-1: bp_level flips and the counter clears.
  - Synchronised input == bp_level: counter clears.
  - Latency from a clean edge: 2 + (2^DEBOUNCE_W-1) cycles.
- bp_press[i] is high for exactly one cycle on a bp_level[i] 0->1 transition and is forced 0 while rst_out=1. Debounce itself runs during rst_out; only rst_n clears it.
- led_mode advances 0->1->2->0 on bp_press[NB_BP-1]. It is cleared by rst_out, so led_mode=0 after any reset.
- Mode 0, legacy: on pitch_wheel, led <= note[NB_LED+1:2]; held otherwise.
- Mode 1, activity:
  - note_pressed loads the stretch counter with 2^ACT_W-1; it decrements to 0 and saturates.
  - led[0] = (counter != 0).
  - led[NB_LED-1:1] = bp_level[NB_LED-2:0], zero-padded if NB_BP is smaller.
- Mode 2, status: led[0]=rst_out; other LEDs 0.
- On a mode change, led updates combinationally from the new mode's sources. Mode 0 retains its last captured value, cleared by rst_out.
- Simultaneous pulses:
  - pitch_wheel and note_pressed in the same cycle: each is handled by its own path.
  - rst_cmd and bp_press in the same cycle: rst_cmd wins, so led_mode=0.

Optional Feature:
- Macro: SYS_CTRL_BP_RST_EN.
- Defined:
  - A long-press counter increments while bp_level[0]=1 and clears when it is 0.
  - Reaching 2^LONG_W-1 produces one internal reset request, treated exactly like rst_cmd.
  - The counter saturates, so only one request fires per hold.
- Undefined: no long-press logic; bp[0] is only an ordinary button.

Test Plan (DEBOUNCE_W=3, RST_CYCLES=15, ACT_W=4, LONG_W=5):
- Release rst_n at cycle 0 -> rst_out=1 through cycle 14, 0 from cycle 15; led=0, led_mode=0.
- rst_cmd pulse at cycle 40 -> rst_out=1 at cycles 41..55, 0 at 56; second rst_cmd at 45 -> rst_out held until 60.
- bp[1] bounces 1,0,1,0 for 6 cycles, then steady 1 -> one bp_press[1] pulse, 9 cycles after the steady edge; no pulse from the bounce.
- Mode 0: pitch_wheel with note=7'h2C -> led=4'b1011; second press of bp[3] -> led_mode=2, led=4'b0000.
- Mode 1: note_pressed -> led[0]=1 for 15 cycles then 0; bp[0] held -> led[1]=1.
- With SYS_CTRL_BP_RST_EN: hold bp[0] 60 cycles -> exactly one reset stretch, led_mode=0. Without the macro -> rst_out stays 0.
